// File: rtl/ntt_result_collector.sv
// Collects the NTT core's even/odd-interleaved result stream into natural order,
// applies the final conditional subtraction of q, and streams the ring to the host.
module ntt_result_collector #(
   parameter int DATA_W    = 32,
   parameter int MAX_DEPTH = 10,
   parameter int IDX_W     = MAX_DEPTH
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [3:0]        ring_depth,
   input  logic [DATA_W-1:0] q,
   input  logic              done,
   input  logic              res_valid,
   input  logic [DATA_W-1:0] res_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [IDX_W-1:0]  out_index,
   output logic              busy,
   output logic              collected,
   output logic              overflow,
   output logic              err_cfg
);

   localparam int DEPTH = 1 << MAX_DEPTH;

   typedef enum logic [1:0] {IDLE, WAIT_DONE, CAPTURE, DRAIN} state_t;

   state_t              state_reg;
   logic                busy_reg;
   logic                err_cfg_reg;
   logic                overflow_reg;
   logic                captured_reg;
   logic [IDX_W:0]      n_reg;
   logic [DATA_W-1:0]   q_reg;

   logic [IDX_W-1:0]    m_reg;
   logic                red_valid_reg;
   logic                red_last_reg;
   logic [DATA_W-1:0]   red_data_reg;
   logic [IDX_W-1:0]    red_addr_reg;
   logic                wr_en_reg;
   logic [IDX_W-1:0]    wr_addr_reg;
   logic [DATA_W-1:0]   wr_data_reg;
   logic                collected_reg;

   logic [DATA_W-1:0]   mem [DEPTH];
   logic [DATA_W-1:0]   rd_data_reg;
   logic [IDX_W:0]      rd_cnt_reg;
   logic                rd_pend_reg;
   logic [IDX_W-1:0]    rd_index_reg;
   logic                drain_go_reg;
   logic                out_valid_reg;
   logic [DATA_W-1:0]   out_data_reg;
   logic [IDX_W-1:0]    out_index_reg;
   logic                skid_valid_reg;
   logic [DATA_W-1:0]   skid_data_reg;
   logic [IDX_W-1:0]    skid_index_reg;

   logic                depth_ok;
   logic                start_ok;
   logic                cap_word;
   logic                m_last;
   logic [IDX_W-1:0]    half;
   logic [IDX_W-1:0]    cap_addr;
   logic [DATA_W-1:0]   reduced;
   logic                pop;
   logic [1:0]          occ;
   logic                space;
   logic                rd_issue;
   logic                last_beat;

   assign depth_ok = (ring_depth != 4'd0) && (ring_depth <= 4'(MAX_DEPTH));
   assign start_ok = (state_reg == IDLE) && start && depth_ok;
   assign cap_word = (state_reg == CAPTURE) && res_valid;
   assign m_last   = ({1'b0, m_reg} == (n_reg - 1'b1));
   assign half     = n_reg[IDX_W:1];
   // Even words fill the lower half, odd words the upper half.
   assign cap_addr = (m_reg >> 1) + (m_reg[0] ? half : '0);
   assign reduced  = (res_data >= q_reg) ? (res_data - q_reg) : res_data;

   // Reads are issued only when the read slot, output and skid registers can absorb them.
   assign pop       = out_valid_reg & out_ready;
   assign occ       = 2'(rd_pend_reg) + 2'(out_valid_reg) + 2'(skid_valid_reg);
   assign space     = (occ - {1'b0, pop}) < 2'd2;
   assign rd_issue  = (state_reg == DRAIN) && (collected_reg || drain_go_reg) &&
                      (rd_cnt_reg != n_reg) && space;
   assign last_beat = pop && ({1'b0, out_index_reg} == (n_reg - 1'b1));

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg    <= IDLE;
         busy_reg     <= 1'b0;
         err_cfg_reg  <= 1'b0;
         overflow_reg <= 1'b0;
         captured_reg <= 1'b0;
         n_reg        <= '0;
         q_reg        <= '0;
      end else begin
         err_cfg_reg <= 1'b0;
         if (res_valid && ((state_reg == DRAIN) || ((state_reg == IDLE) && captured_reg)))
            overflow_reg <= 1'b1;
         case (state_reg)
            IDLE: begin
               if (start) begin
                  if (depth_ok) begin
                     n_reg        <= (IDX_W+1)'(1) << ring_depth;
                     q_reg        <= q;
                     overflow_reg <= 1'b0;
                     captured_reg <= 1'b0;
                     busy_reg     <= 1'b1;
                     state_reg    <= WAIT_DONE;
                  end else begin
                     err_cfg_reg <= 1'b1;
                  end
               end
            end
            WAIT_DONE: begin
               if (done)
                  state_reg <= CAPTURE;
            end
            CAPTURE: begin
               if (res_valid && m_last) begin
                  captured_reg <= 1'b1;
                  state_reg    <= DRAIN;
               end
            end
            DRAIN: begin
               if (last_beat) begin
                  busy_reg  <= 1'b0;
                  state_reg <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         m_reg         <= '0;
         red_valid_reg <= 1'b0;
         red_last_reg  <= 1'b0;
         red_data_reg  <= '0;
         red_addr_reg  <= '0;
         wr_en_reg     <= 1'b0;
         wr_addr_reg   <= '0;
         wr_data_reg   <= '0;
         collected_reg <= 1'b0;
      end else begin
         red_valid_reg <= cap_word;
         if (start_ok)
            m_reg <= '0;
         else if (cap_word) begin
            m_reg        <= m_reg + 1'b1;
            red_data_reg <= reduced;
            red_addr_reg <= cap_addr;
            red_last_reg <= m_last;
         end
         wr_en_reg     <= red_valid_reg;
         wr_addr_reg   <= red_addr_reg;
         wr_data_reg   <= red_data_reg;
         collected_reg <= red_valid_reg & red_last_reg;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en_reg)
         mem[wr_addr_reg] <= wr_data_reg;
      if (rd_issue)
         rd_data_reg <= mem[rd_cnt_reg[IDX_W-1:0]];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_cnt_reg     <= '0;
         rd_pend_reg    <= 1'b0;
         rd_index_reg   <= '0;
         drain_go_reg   <= 1'b0;
         out_valid_reg  <= 1'b0;
         out_data_reg   <= '0;
         out_index_reg  <= '0;
         skid_valid_reg <= 1'b0;
         skid_data_reg  <= '0;
         skid_index_reg <= '0;
      end else begin
         rd_pend_reg <= rd_issue;
         if (start_ok) begin
            rd_cnt_reg   <= '0;
            drain_go_reg <= 1'b0;
         end else begin
            if (rd_issue) begin
               rd_cnt_reg   <= rd_cnt_reg + 1'b1;
               rd_index_reg <= rd_cnt_reg[IDX_W-1:0];
            end
            if (collected_reg)
               drain_go_reg <= 1'b1;
            else if (last_beat)
               drain_go_reg <= 1'b0;
         end
         // The skid register catches the in-flight read while the host stalls.
         if (pop || !out_valid_reg) begin
            if (skid_valid_reg) begin
               out_valid_reg  <= 1'b1;
               out_data_reg   <= skid_data_reg;
               out_index_reg  <= skid_index_reg;
               skid_valid_reg <= rd_pend_reg;
               skid_data_reg  <= rd_data_reg;
               skid_index_reg <= rd_index_reg;
            end else if (rd_pend_reg) begin
               out_valid_reg <= 1'b1;
               out_data_reg  <= rd_data_reg;
               out_index_reg <= rd_index_reg;
            end else begin
               out_valid_reg <= 1'b0;
            end
         end else if (rd_pend_reg) begin
            skid_valid_reg <= 1'b1;
            skid_data_reg  <= rd_data_reg;
            skid_index_reg <= rd_index_reg;
         end
      end
   end

   assign out_valid = out_valid_reg;
   assign out_data  = out_data_reg;
   assign out_index = out_index_reg;
   assign busy      = busy_reg;
   assign collected = collected_reg;
   assign overflow  = overflow_reg;
   assign err_cfg   = err_cfg_reg;

endmodule
